addsub_pipe: RTL and testbench

- Parametrised, pipelined two-operand adder/subtractor.
- Successor to the fixed-width ripple adders used in the FP add/sub datapath for mantissa (25/26-bit) and exponent (8/9/10-bit) arithmetic.
- Splits the carry chain into CHUNKS registered segments. Adds a subtract mode, an external carry-in, status flags, and a valid/ready handshake with back-pressure.

---
 rtl/addsub_pipe.sv | 126 ++++++++++++
 tb/tb_addsub_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_pipe.sv
// Pipelined two-operand adder/subtractor: the carry chain is cut into CHUNKS
// registered segments so each stage adds one chunk with the carry handed down.
module addsub_pipe #(
    parameter int WIDTH  = 26,
    parameter int CHUNKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW   = (WIDTH + CHUNKS - 1) / CHUNKS;
    localparam int LAST = CHUNKS - 1;

    // Handshake: an operand moves in when in_valid && in_ready, a result moves out
    // when out_valid && out_ready; the whole pipe advances or holds as one unit.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] b_in;
    assign b_in = sub ? ~in2 : in2;

    genvar k;
    generate
        for (k = 0; k < CHUNKS; k++) begin : g_stage
            localparam int LO = k * CW;
            localparam int HI = (k * CW + CW < WIDTH) ? (k * CW + CW) : WIDTH;

            logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
            logic             c_i, m_i, v_i, c_n, m_n;
            logic [WIDTH-1:0] s_q;
            logic             c_q, v_q;

            if (k == 0) begin : g_head
                assign a_i = in1;
                assign b_i = b_in;
                assign s_i = '0;
                assign c_i = sub | cin;
                assign m_i = 1'b0;
                assign v_i = in_valid && in_ready;
            end else begin : g_body
                assign a_i = g_stage[k-1].g_ops.a_q;
                assign b_i = g_stage[k-1].g_ops.b_q;
                assign s_i = g_stage[k-1].s_q;
                assign c_i = g_stage[k-1].c_q;
                assign m_i = g_stage[k-1].g_ops.m_q;
                assign v_i = g_stage[k-1].v_q;
            end

            // m_n keeps the carry into the MSB so overflow can be formed at the end.
            always_comb begin : chunk_add
                s_n = s_i;
                c_n = c_i;
                m_n = m_i;
                for (int i = LO; i < HI; i++) begin
                    s_n[i] = a_i[i] ^ b_i[i] ^ c_n;
                    if (i == WIDTH - 1) begin
                        m_n = c_n;
                    end
                    c_n = (a_i[i] & b_i[i]) | (c_n & (a_i[i] ^ b_i[i]));
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    s_q <= '0;
                    c_q <= 1'b0;
                end else if (adv) begin
                    v_q <= v_i;
                    s_q <= s_n;
                    c_q <= c_n;
                end
            end

            // Only stages with a successor need to carry the operands forward.
            if (k < LAST) begin : g_ops
                logic [WIDTH-1:0] a_q, b_q;
                logic             m_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                        m_q <= 1'b0;
                    end else if (adv) begin
                        a_q <= a_i;
                        b_q <= b_i;
                        m_q <= m_n;
                    end
                end
            end
        end
    endgenerate

    logic zero_q, ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            zero_q <= (g_stage[LAST].s_n == '0);
            ovf_q  <= g_stage[LAST].m_n ^ g_stage[LAST].c_n;
        end
    end

    assign out_valid = g_stage[LAST].v_q;
    assign S         = g_stage[LAST].s_q;
    assign Cout      = g_stage[LAST].c_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe (WIDTH=26, CHUNKS=2): vector table, back-to-back stream,
// back-pressure, mid-flight reset and a random phase, all checked via exp_q.
module tb_addsub_pipe;

    localparam int W = 26;
    typedef logic [W+2:0] rec_t;  // {S, Cout, ovf, zero}

    typedef struct {
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic         sub;
        logic         cin;
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;
    logic         zero;

    addsub_pipe #(.WIDTH(W), .CHUNKS(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .Cout(Cout), .ovf(ovf), .zero(zero)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;
    rec_t exp_q[$];
    int   out_cyc_q[$];
    int   acc_cyc;
    logic done_flag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic rec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        logic [W:0]   t;
        logic [W-1:0] bb;
        logic         c0;
        logic         v;
        bb = s ? ~b : b;
        c0 = s | c;
        t  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        v  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return {t[W-1:0], t[W], v, (t[W-1:0] == '0)};
    endfunction

    // driver: present one operand and wait (bounded) for it to be accepted
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic c, input rec_t e);
        int guard;
        @(negedge clk);
        in1 = a; in2 = b; sub = s; cin = c; in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 (t=%0t)", $time);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_left", exp_q.size(), 0);
    endtask

    // scoreboard: every output transfer pops and compares the oldest expectation
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got S=%0h expected no result (t=%0t)", S, $time);
            end else begin
                check("result", {S, Cout, ovf, zero}, exp_q.pop_front());
                out_cyc_q.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[10];
        rec_t         hold_exp;
        int           a0;
        logic [W-1:0] ra, rb;
        logic         rs, rc;

        vecs[0] = '{26'h3FFFFFF, 26'h0000001, 1'b0, 1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{26'h0000005, 26'h0000007, 1'b1, 1'b0, 26'h3FFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{26'h0000007, 26'h0000005, 1'b1, 1'b0, 26'h0000002, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{26'h1FFFFFF, 26'h0000001, 1'b0, 1'b0, 26'h2000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{26'h0001FFF, 26'h0000000, 1'b0, 1'b1, 26'h0002000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{26'h0000000, 26'h0000000, 1'b0, 1'b0, 26'h0000000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{26'h0000005, 26'h0000005, 1'b1, 1'b0, 26'h0000000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{26'h2000000, 26'h0000001, 1'b1, 1'b0, 26'h1FFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{26'h0000000, 26'h0000000, 1'b1, 1'b1, 26'h0000000, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 1'b1, 26'h3FFFFFF, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b1; done_flag = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_S", S, 0);
        check("rst_Cout", Cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // first vector by hand to pin the two-cycle latency
        send(vecs[0].in1, vecs[0].in2, vecs[0].sub, vecs[0].cin,
             {vecs[0].s, vecs[0].cout, vecs[0].ovf, vecs[0].zero});
        @(negedge clk);
        #1;
        check("latency_cycle1_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("latency_cycle2_valid", out_valid, 1);
        drain();

        for (int i = 1; i < 10; i++) begin
            send(vecs[i].in1, vecs[i].in2, vecs[i].sub, vecs[i].cin,
                 {vecs[i].s, vecs[i].cout, vecs[i].ovf, vecs[i].zero});
        end
        drain();

        // throughput: (i, 2i) back to back, results 3i on consecutive cycles
        out_cyc_q.delete();
        send(26'd0, 26'd0, 1'b0, 1'b0, {26'd0, 1'b0, 1'b0, 1'b1});
        a0 = acc_cyc;
        for (int i = 1; i < 8; i++) begin
            send(W'(i), W'(2 * i), 1'b0, 1'b0, {W'(3 * i), 1'b0, 1'b0, 1'b0});
        end
        drain();
        check("tput_count", out_cyc_q.size(), 8);
        if (out_cyc_q.size() == 8) begin
            check("tput_first_latency", out_cyc_q[0] - a0, 2);
            check("tput_span", out_cyc_q[7] - out_cyc_q[0], 7);
        end

        // back-pressure: results must hold while out_ready is low
        out_ready = 1'b0;
        hold_exp  = model(26'd100, 26'd200, 1'b0, 1'b0);
        send(26'd100, 26'd200, 1'b0, 1'b0, hold_exp);
        send(26'd50, 26'd20, 1'b1, 1'b0, model(26'd50, 26'd20, 1'b1, 1'b0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_hold", {S, Cout, ovf, zero}, hold_exp);
        end
        @(negedge clk);
        out_ready = 1'b1;
        send(26'h3000000, 26'h1000000, 1'b0, 1'b1, model(26'h3000000, 26'h1000000, 1'b0, 1'b1));
        drain();

        // reset while two operations are in flight
        send(26'd10, 26'd20, 1'b0, 1'b0, model(26'd10, 26'd20, 1'b0, 1'b0));
        send(26'd30, 26'd40, 1'b0, 1'b0, model(26'd30, 26'd40, 1'b0, 1'b0));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_S", S, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("midrst_no_stale", out_valid, 0);
        end
        send(26'd1, 26'd1, 1'b0, 1'b0, {26'd2, 1'b0, 1'b0, 1'b0});
        drain();

        // random operands with random back-pressure
        fork
            begin
                for (int r = 0; r < 24; r++) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    rc = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, rc, model(ra, rb, rs, rc));
                end
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
